// File: rtl/conv_stream_sequencer_if.sv
// -----------------------------------------------------------------------------
// conv_stream_sequencer_if
//
// Purpose:
//   Bundles the byte-stream handshakes and the parallel systolic-array bus of
//   conv_stream_sequencer into one interface. clk and rst are not part of it.
//
// Signals:
//   in_data   [7:0]   operand byte                      (environment -> seq)
//   in_valid          in_data is valid                  (environment -> seq)
//   in_ready          sequencer accepts a byte          (seq -> environment)
//   out_data  [7:0]   result byte                       (seq -> environment)
//   out_valid         out_data is valid                 (seq -> environment)
//   out_ready         downstream accepts the result     (environment -> seq)
//   arr_rst           active-high reset to the array    (seq -> array)
//   arr_i     [127:0] image operands i00..i33, row-major, i00 in MSB byte
//   arr_f     [71:0]  filter operands f00..f22, row-major, f00 in MSB byte
//   arr_o     [31:0]  array results o00,o01,o10,o11, o00 in MSB byte
//   busy              sequencer is not in its LOAD state
//
// Modports:
//   master : the environment (byte source, result sink, array results)
//   slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface conv_stream_sequencer_if;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic         arr_rst;
  logic [127:0] arr_i;
  logic [71:0]  arr_f;
  logic [31:0]  arr_o;
  logic         busy;

  modport master (
    output in_data, in_valid, out_ready, arr_o,
    input  in_ready, out_data, out_valid, arr_rst, arr_i, arr_f, busy
  );

  modport slave (
    input  in_data, in_valid, out_ready, arr_o,
    output in_ready, out_data, out_valid, arr_rst, arr_i, arr_f, busy
  );
endinterface : conv_stream_sequencer_if

// File: rtl/conv_stream_sequencer.sv
// -----------------------------------------------------------------------------
// conv_stream_sequencer
//
// Purpose:
//   Byte-serial front/back end for the 3x3-filter / 4x4-input / 2x2-output
//   systolic convolution array. It collects 16 image bytes followed by 9
//   filter bytes, presents them to the array as parallel buses, releases the
//   array reset for RUN_CYCLES cycles, captures the four 8-bit results and
//   streams them out one byte at a time with valid/ready.
//
// Parameters:
//   RUN_CYCLES  cycles the array is held out of reset before sampling (>= 2)
//   N_IN        image operand bytes (16 for the 4x4 array)
//   N_F         filter operand bytes (9 for the 3x3 array)
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   conv_stream_sequencer_if.slave (stream handshakes + array bus)
//
// Operation:
//   LOAD  : in_ready=1, arr_rst=1. Byte k lands in slot k (0..15 image,
//           16..24 filter). Accepting the last slot starts RUN.
//   RUN   : arr_rst=0, busy=1, counter counts 0..RUN_CYCLES-1. On the last
//           count arr_o is registered and DRAIN starts.
//   DRAIN : arr_rst=1, out_valid=1, results leave in order o00,o01,o10,o11.
//           The fourth accepted result returns the block to LOAD.
// -----------------------------------------------------------------------------
module conv_stream_sequencer #(
  parameter int RUN_CYCLES = 50,
  parameter int N_IN       = 16,
  parameter int N_F        = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  conv_stream_sequencer_if.slave bus
);

  // ---------------------------------------------------------------------------
  // Local constants
  // ---------------------------------------------------------------------------
  localparam int              N_SLOTS   = N_IN + N_F;
  localparam int              CNT_W     = (RUN_CYCLES > 2) ? $clog2(RUN_CYCLES) : 1;
  localparam logic [4:0]      LAST_SLOT = 5'(N_SLOTS - 1);
  localparam logic [4:0]      LAST_IMG  = 5'(N_IN - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RUN_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t            r_state;
  logic [4:0]        r_idx;        // next operand slot to fill
  logic [CNT_W-1:0]  r_cnt;        // array run counter
  logic [1:0]        r_d;          // next result to drain
  logic [127:0]      r_arr_i;
  logic [71:0]       r_arr_f;
  logic [0:3][7:0]   r_res;        // r_res[0] = o00 ... r_res[3] = o11
  logic              r_arr_rst;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [7:0]        r_out_data;
  logic              r_busy;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic       w_in_ready;
  logic       w_in_fire;
  logic       w_out_fire;
  logic [3:0] w_i_sel;    // byte lane of the current image slot, 0 = LSB
  logic [3:0] w_f_sel;    // byte lane of the current filter slot, 0 = LSB

  // in_ready must read low in any cycle where rst is high, including the
  // cycle in which rst is first raised, so it is qualified with rst here
  // rather than only through the registered state.
  assign w_in_ready = r_in_ready & ~rst;
  assign w_in_fire  = bus.in_valid & w_in_ready;
  assign w_out_fire = r_out_valid & bus.out_ready;

  // Slot 0 is the most significant byte, so the lane index counts down from
  // the last slot of each bus.
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_i_sel = 4'd0;
    w_f_sel = 4'd0;
    w_i_sel = 4'(LAST_IMG - r_idx);
    w_f_sel = 4'(LAST_SLOT - r_idx);
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the operand and result registers are wide, but they are driven
      // straight onto the array buses and must read zero after reset, so they
      // are cleared here like the control state.
      r_state     <= LOAD;
      r_idx       <= 5'd0;
      r_cnt       <= '0;
      r_d         <= 2'd0;
      r_arr_i     <= '0;
      r_arr_f     <= '0;
      r_res       <= '0;
      r_arr_rst   <= 1'b1;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'd0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_in_fire) begin
            if (r_idx <= LAST_IMG) begin
              r_arr_i[{w_i_sel, 3'b000} +: 8] <= bus.in_data;
            end else begin
              r_arr_f[{w_f_sel, 3'b000} +: 8] <= bus.in_data;
            end

            if (r_idx == LAST_SLOT) begin
              // Last operand: release the array on the very next cycle.
              r_state    <= RUN;
              r_idx      <= 5'd0;
              r_cnt      <= '0;
              r_in_ready <= 1'b0;
              r_arr_rst  <= 1'b0;
              r_busy     <= 1'b1;
            end else begin
              r_idx <= r_idx + 5'd1;
            end
          end
        end

        RUN: begin
          if (r_cnt == LAST_CNT) begin
            // arr_rst has been low for RUN_CYCLES cycles at this edge; take
            // the results and put the array back into reset.
            r_res       <= bus.arr_o;
            r_out_data  <= bus.arr_o[31:24];
            r_out_valid <= 1'b1;
            r_arr_rst   <= 1'b1;
            r_d         <= 2'd0;
            r_cnt       <= '0;
            r_state     <= DRAIN;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        DRAIN: begin
          if (w_out_fire) begin
            if (r_d == 2'd3) begin
              r_state     <= LOAD;
              r_d         <= 2'd0;
              r_out_valid <= 1'b0;
              r_out_data  <= 8'd0;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b0;
            end else begin
              // Preload the next result so out_data changes only on a
              // completed transfer and is stable under backpressure.
              r_d        <= r_d + 2'd1;
              r_out_data <= r_res[r_d + 2'd1];
            end
          end
        end

        default: begin
          r_state <= LOAD;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.arr_rst   = r_arr_rst;
  assign bus.arr_i     = r_arr_i;
  assign bus.arr_f     = r_arr_f;
  assign bus.busy      = r_busy;

endmodule : conv_stream_sequencer

// File: doc/conv_stream_sequencer.md
Name: conv_stream_sequencer

Overview:
- Streaming front/back end for the 3x3-filter / 4x4-input / 2x2-output systolic convolution array.
- Accepts a byte stream of image and filter operands, then presents them to the array as parallel buses.
- Controls the array reset to run one computation, captures the four 8-bit results, and streams them out with valid/ready.
- This is the writer/reader for the array's parallel operand/result interface, so software-side logic can talk to it one byte at a time.

Parameters:
- RUN_CYCLES, 50, cycles the array is held out of reset before its outputs are sampled (must be >= 2).
- N_IN, 16, number of image operand bytes; fixed at 16 for the 4x4 array.
- N_F, 9, number of filter operand bytes; fixed at 9 for the 3x3 array.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  8  operand byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts an operand byte this cycle.
- out_data  output  8  result byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the result byte.
- arr_rst  output  1  reset driven to the systolic array (active high).
- arr_i  output  128  image operands, i00 in [127:120] through i33 in [7:0], row-major.
- arr_f  output  72  filter operands, f00 in [71:64] through f22 in [7:0], row-major.
- arr_o  input  32  array results, o00 in [31:24], o01 in [23:16], o10 in [15:8], o11 in [7:0].
- busy  output  1  high whenever state is not LOAD.

Behaviour:
- Reset (rst high at the clock edge):
  - state goes to LOAD; byte index, run counter and drain index go to 0.
  - arr_i and arr_f go to 0; result registers go to 0.
  - arr_rst=1, out_valid=0, out_data=0, busy=0.
  - in_ready=0 for every cycle in which rst is high.
- States:
  - LOAD: in_ready=1 (when rst is low), arr_rst=1.
    - A byte is accepted when in_valid and in_ready are both high.
    - Byte k (0..24) is stored into slot k: slots 0..15 are i00..i33, slots 16..24 are f00..f22.
    - When byte 24 is accepted, go to RUN and clear the run counter.
  - RUN: in_ready=0, arr_rst=0, busy=1.
    - The counter increments every cycle.
    - In the cycle where counter == RUN_CYCLES-1, register arr_o into result[0..3] and go to DRAIN.
    - arr_rst stays low for exactly RUN_CYCLES cycles.
  - DRAIN: arr_rst=1 (asserted again on entry), out_valid=1.
    - out_data = result[d], in order o00, o01, o10, o11.
    - On out_valid & out_ready, d increments. After d=3 is accepted, go to LOAD with d=0.
- Latency: if the last operand is accepted at edge T:
  - arr_rst falls after T.
  - arr_o is captured at edge T+RUN_CYCLES.
  - out_valid rises after edge T+RUN_CYCLES.
- Handshake rules:
  - While out_valid is high and out_ready is low, out_data is held stable.
  - in_valid is ignored outside LOAD.
  - out_ready is ignored outside DRAIN.
- Operand registers:
  - They keep their values after a run; the next LOAD overwrites them slot by slot.
  - Only rst clears them.
- Result width: arr_o bytes are passed through unmodified (8-bit, no saturation or sign handling).
- Reset mid-operation (LOAD, RUN or DRAIN): the partial load or pending results are discarded and the block returns to the reset state on the next edge.
- No simultaneous input and output handshakes: in_ready and out_valid are never both high.

Test Plan:
- Load and packing:
  - Stimulus: stream 09,08,02,06,00,04,01,06,04,0A,01,01,02,02,09,09 then 03,02,00,02,00,01,03,01,01 with in_valid held high.
  - Required: in_ready high for 25 accepts then low; arr_i=128'h09080206000401060 40A0101020209 09 (i.e. 0908020600040106040A010102020909); arr_f=72'h030200020001030101; arr_rst falls the cycle after the last accept.
- Run timing:
  - Stimulus: same load, with an array stub driving arr_o=32'h434A223B.
  - Required: arr_rst low for exactly 50 cycles; out_valid rises 50 cycles after the last accept; outputs 67, 74, 34, 59 in that order; in_ready returns high after the 4th accept.
- Backpressure:
  - Stimulus: out_ready toggles 0,0,1,0,1,1,0,1.
  - Required: each result byte is held stable until accepted; exactly 4 transfers occur, with no duplicates or drops.
- Input gaps:
  - Stimulus: in_valid deasserted randomly during LOAD, and in_valid held high during RUN and DRAIN.
  - Required: slot order is preserved; bytes presented during RUN or DRAIN are never accepted.
- Reset mid-operation:
  - Stimulus: assert rst after 10 bytes, and separately after 2 results have drained.
  - Required: out_valid=0, arr_rst=1, arr_i=0 and in_ready=0 during reset; the next load starts at slot 0 and produces the full 4 results.
- Back-to-back runs:
  - Stimulus: a second load with a different filter (all 01) immediately after the drain.
  - Required: arr_f=72'h010101010101010101; the second result set is captured from arr_o of the second run only.
